clock_mode_ctrl: RTL and testbench

Front-panel controller for the six-digit multiplexed clock (HH:MM:SS). It synchronises and debounces the four push-buttons b1..b4 and runs the run/pause/set state machine. It gates the 1 Hz time-base tick into the time counters and issues per-field increment/decrement pulses. It also produces a blink blanking mask that the display multiplexer ANDs into its power (digit-enable) outputs.

---
 rtl/clock_mode_ctrl.sv | 172 +++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// Front-panel controller for the HH:MM:SS multiplexed clock.
// Synchronises and debounces b1..b4, runs the run/pause/set state machine,
// gates the 1 Hz tick, issues per-field inc/dec pulses and a blink mask.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   b1..b4         raw buttons: pause/resume, field select, increment, decrement
//   tick_in        one-cycle time-base pulse
//   tick_out       registered gated tick (passes only in RUN)
//   paused         high in every state except RUN
//   sel            0 none, 1 hours, 2 minutes, 3 seconds
//   inc, dec       one-hot {hours, minutes, seconds} adjust pulses
//   blank          per-digit blank mask, [5:4] hours, [3:2] minutes, [1:0] seconds
module clock_mode_ctrl #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned BLINK_DIV  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       b1,
   input  logic       b2,
   input  logic       b3,
   input  logic       b4,
   input  logic       tick_in,
   output logic       tick_out,
   output logic       paused,
   output logic [1:0] sel,
   output logic [2:0] inc,
   output logic [2:0] dec,
   output logic [5:0] blank
);

   localparam int unsigned NB = 4;
   localparam int unsigned DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   typedef enum logic [2:0] {RUN, PAUSE, SET_H, SET_M, SET_S} state_t;

   logic [NB-1:0] raw;
   logic [NB-1:0] sync1, sync2, deb, deb_d, press;
   logic [DW-1:0] deb_cnt [NB];

   state_t        state, state_nxt;
   logic [2:0]    field, inc_nxt, dec_nxt;
   logic [1:0]    sel_nxt;
   logic [5:0]    blank_nxt;
   logic          enter_set;
   logic [BW-1:0] bcnt, bcnt_nxt;
   logic          phase, phase_nxt;

   // Bit i corresponds to button b(i+1); index 0 has the highest priority.
   assign raw = {b4, b3, b2, b1};

   // Synchroniser, debounce counter and registered rising-edge press pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         press <= '0;
         for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_d <= deb;
         press <= deb & ~deb_d;
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] != deb[i]) begin
               // The DEB_CYCLES-th differing sample flips the level.
               if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                  deb[i]     <= ~deb[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + DW'(1);
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   // Next state, adjust pulses, blink counter and blank mask.
   always_comb begin
      state_nxt = state;
      inc_nxt   = '0;
      dec_nxt   = '0;
      field     = '0;
      sel_nxt   = '0;
      enter_set = 1'b0;
      bcnt_nxt  = bcnt;
      phase_nxt = phase;
      blank_nxt = '0;

      case (state)
         SET_H:   field = 3'b100;
         SET_M:   field = 3'b010;
         SET_S:   field = 3'b001;
         default: field = 3'b000;
      endcase

      // Priority b1 > b2 > b3 > b4; losers are dropped.
      if (press[0]) begin
         state_nxt = (state == RUN) ? PAUSE : RUN;
      end else if (press[1]) begin
         case (state)
            PAUSE:   state_nxt = SET_H;
            SET_H:   state_nxt = SET_M;
            SET_M:   state_nxt = SET_S;
            SET_S:   state_nxt = PAUSE;
            default: state_nxt = state;
         endcase
      end else if (press[2]) begin
         inc_nxt = field;
      end else if (press[3]) begin
         dec_nxt = field;
      end

      case (state_nxt)
         SET_H:   sel_nxt = 2'd1;
         SET_M:   sel_nxt = 2'd2;
         SET_S:   sel_nxt = 2'd3;
         default: sel_nxt = 2'd0;
      endcase
      enter_set = (sel_nxt != 2'd0) && (state_nxt != state);

      // Any field change or adjustment restarts the visible half-period.
      if (enter_set || (inc_nxt != 3'b000) || (dec_nxt != 3'b000)) begin
         bcnt_nxt  = '0;
         phase_nxt = 1'b0;
      end else if (bcnt == BW'(BLINK_DIV - 1)) begin
         bcnt_nxt  = '0;
         phase_nxt = ~phase;
      end else begin
         bcnt_nxt  = bcnt + BW'(1);
      end

      case (sel_nxt)
         2'd1:    blank_nxt[5:4] = {2{phase_nxt}};
         2'd2:    blank_nxt[3:2] = {2{phase_nxt}};
         2'd3:    blank_nxt[1:0] = {2{phase_nxt}};
         default: blank_nxt      = '0;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         tick_out <= 1'b0;
         paused   <= 1'b0;
         sel      <= '0;
         inc      <= '0;
         dec      <= '0;
         blank    <= '0;
         bcnt     <= '0;
         phase    <= 1'b0;
      end else begin
         state    <= state_nxt;
         tick_out <= tick_in && (state == RUN);
         paused   <= (state_nxt != RUN);
         sel      <= sel_nxt;
         inc      <= inc_nxt;
         dec      <= dec_nxt;
         blank    <= blank_nxt;
         bcnt     <= bcnt_nxt;
         phase    <= phase_nxt;
      end
   end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl (DEB_CYCLES=4, BLINK_DIV=8).
module tb_clock_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       b1, b2, b3, b4;
   logic       tick_in;
   logic       tick_out;
   logic       paused;
   logic [1:0] sel;
   logic [2:0] inc;
   logic [2:0] dec;
   logic [5:0] blank;

   int checks   = 0;
   int failures = 0;

   logic [2:0] inc_or, dec_or;
   int         inc_n, dec_n;

   always #5 clk = ~clk;

   clock_mode_ctrl #(.DEB_CYCLES(4), .BLINK_DIV(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .b1       (b1),
      .b2       (b2),
      .b3       (b3),
      .b4       (b4),
      .tick_in  (tick_in),
      .tick_out (tick_out),
      .paused   (paused),
      .sel      (sel),
      .inc      (inc),
      .dec      (dec),
      .blank    (blank)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pulse tick_in for one cycle and check the gated copy one edge later.
   task automatic tick_test(input string tag, input logic exp);
      @(negedge clk);
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      check(tag, 32'(tick_out), 32'(exp));
      repeat (8) @(negedge clk);
   endtask

   // Hold the masked buttons for 'hold' cycles inside a 24-cycle window,
   // recording every inc/dec value seen.
   task automatic press(input logic [3:0] mask, input int hold);
      inc_or = '0;
      dec_or = '0;
      inc_n  = 0;
      dec_n  = 0;
      @(negedge clk);
      {b4, b3, b2, b1} = mask;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (k == hold - 1) {b4, b3, b2, b1} = 4'b0000;
         inc_or = inc_or | inc;
         dec_or = dec_or | dec;
         if (inc != 3'b000) inc_n++;
         if (dec != 3'b000) dec_n++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      {b4, b3, b2, b1} = 4'b0000;
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tick_out", 32'(tick_out), 32'd0);
      check("rst_paused",   32'(paused),   32'd0);
      check("rst_sel",      32'(sel),      32'd0);
      check("rst_inc",      32'(inc),      32'd0);
      check("rst_dec",      32'(dec),      32'd0);
      check("rst_blank",    32'(blank),    32'd0);
      rst_n = 1'b1;

      // Ticks pass through in RUN.
      tick_test("run_tick0", 1'b1);
      tick_test("run_tick1", 1'b1);
      check("run_paused", 32'(paused), 32'd0);
      check("run_blank",  32'(blank),  32'd0);

      // b1 latency: state changes at edge 7 after the first sample.
      @(negedge clk);
      b1 = 1'b1;
      repeat (7) @(negedge clk);
      check("b1_lat_edge6", 32'(paused), 32'd0);
      @(negedge clk);
      check("b1_lat_edge7", 32'(paused), 32'd1);
      repeat (12) @(negedge clk);
      b1 = 1'b0;
      repeat (12) @(negedge clk);
      check("held_no_repeat", 32'(paused), 32'd1);
      tick_test("pause_tick", 1'b0);

      press(4'b0001, 8);
      check("resume_paused", 32'(paused), 32'd0);
      tick_test("resume_tick", 1'b1);

      // Too-short pulse is ignored.
      press(4'b0001, 3);
      check("short_pulse", 32'(paused), 32'd0);

      // One-cycle glitch inside a long hold still gives a single press.
      @(negedge clk);
      b1 = 1'b1;
      repeat (10) @(negedge clk);
      b1 = 1'b0;
      @(negedge clk);
      b1 = 1'b1;
      repeat (10) @(negedge clk);
      b1 = 1'b0;
      repeat (12) @(negedge clk);
      check("glitch_one_press", 32'(paused), 32'd1);

      // Field select walk with adjustments in SET_M.
      press(4'b0010, 8);
      check("sel_h", 32'(sel), 32'd1);
      press(4'b0010, 8);
      check("sel_m", 32'(sel), 32'd2);
      press(4'b0100, 8);
      check("inc1_val", 32'(inc_or), 32'b010);
      check("inc1_width", 32'(inc_n), 32'd1);
      check("inc1_no_dec", 32'(dec_n), 32'd0);
      press(4'b0100, 8);
      check("inc2_val", 32'(inc_or), 32'b010);
      check("inc2_width", 32'(inc_n), 32'd1);
      press(4'b1000, 8);
      check("dec_val", 32'(dec_or), 32'b010);
      check("dec_width", 32'(dec_n), 32'd1);
      check("dec_no_inc", 32'(inc_n), 32'd0);
      check("sel_m_kept", 32'(sel), 32'd2);
      press(4'b0010, 8);
      check("sel_s", 32'(sel), 32'd3);
      press(4'b0010, 8);
      check("sel_none", 32'(sel), 32'd0);
      check("back_pause", 32'(paused), 32'd1);
      press(4'b0100, 8);
      check("pause_no_inc", 32'(inc_n), 32'd0);

      // Blink in SET_H: entry at edge 7 of the b2 press.
      @(negedge clk);
      b2 = 1'b1;
      repeat (8) @(negedge clk);
      b2 = 1'b0;
      check("sel_h2", 32'(sel), 32'd1);
      check("blink_vis_first", 32'(blank), 32'h00);
      repeat (7) @(negedge clk);
      check("blink_vis_last", 32'(blank), 32'h00);
      @(negedge clk);
      check("blink_blank_first", 32'(blank), 32'h30);
      repeat (7) @(negedge clk);
      check("blink_blank_last", 32'(blank), 32'h30);
      @(negedge clk);
      check("blink_vis_again", 32'(blank), 32'h00);
      repeat (10) @(negedge clk);
      check("blink_pre_inc", 32'(blank), 32'h30);

      // b3 press restarts the visible half-period.
      b3 = 1'b1;
      repeat (7) @(negedge clk);
      check("h_inc_before", 32'(inc), 32'b000);
      @(negedge clk);
      b3 = 1'b0;
      check("h_inc_pulse", 32'(inc), 32'b100);
      @(negedge clk);
      check("h_inc_after", 32'(inc), 32'b000);
      repeat (6) @(negedge clk);
      check("blink_restart_vis", 32'(blank), 32'h00);
      @(negedge clk);
      check("blink_restart_blank", 32'(blank), 32'h30);

      // Simultaneous b1+b3 in SET_S: b1 wins.
      press(4'b0010, 8);
      press(4'b0010, 8);
      check("sel_s2", 32'(sel), 32'd3);
      press(4'b0101, 8);
      check("prio_paused", 32'(paused), 32'd0);
      check("prio_sel", 32'(sel), 32'd0);
      check("prio_no_inc", 32'(inc_n), 32'd0);
      check("prio_blank", 32'(blank), 32'h00);

      // Reset while in SET_M.
      press(4'b0001, 8);
      press(4'b0010, 8);
      press(4'b0010, 8);
      check("pre_rst_sel", 32'(sel), 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_paused", 32'(paused), 32'd0);
      check("mid_rst_sel",    32'(sel),    32'd0);
      check("mid_rst_blank",  32'(blank),  32'd0);
      check("mid_rst_inc",    32'({inc, dec}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick_test("post_rst_tick", 1'b1);
      check("post_rst_paused", 32'(paused), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
